// File: rtl/axi4f_mem_slv_if.sv
// AXI4 bus bundle between the master agent and the memory slave.
// Only the signals the slave actually needs are carried.
interface axi4f_mem_slv_if #(
  parameter int ID_W   = 1,
  parameter int ADDR_W = 32
);
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;

  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi4f_mem_slv.sv
// AXI4 memory slave: independent write and read burst engines over a
// DEPTH x 32-bit word array, one outstanding burst per direction.
module axi4f_mem_slv #(
  parameter int ID_W   = 1,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic           clk,
  input  logic           rst,
  axi4f_mem_slv_if.slave s_axi
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  w_state_e          w_state_q, w_state_d;
  logic [IDX_W-1:0]  w_idx_q, w_idx_d;
  logic [7:0]        w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic              w_fixed_q, w_fixed_d, w_err_q, w_err_d;
  logic              w_over_q, w_over_d, w_bad_q, w_bad_d;
  logic              awready_q, awready_d, wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [ID_W-1:0]   bid_q, bid_d;
  logic              mem_we, w_mis;

  r_state_e          r_state_q, r_state_d;
  logic [IDX_W-1:0]  r_idx_q, r_idx_d;
  logic [7:0]        r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic              r_fixed_q, r_fixed_d, r_err_q, r_err_d;
  logic              arready_q, arready_d, rvalid_q, rvalid_d;
  logic              rlast_q, rlast_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [ID_W-1:0]   rid_q, rid_d;

  logic [31:0]       mem [DEPTH];

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic aw_err, ar_err;
  logic [IDX_W-1:0] aw_idx, ar_idx;

  assign aw_hs  = s_axi.awvalid && awready_q;
  assign w_hs   = s_axi.wvalid && wready_q;
  assign b_hs   = bvalid_q && s_axi.bready;
  assign ar_hs  = s_axi.arvalid && arready_q;
  assign r_hs   = rvalid_q && s_axi.rready;
  assign aw_err = (s_axi.awsize != 3'b010) || s_axi.awburst[1];
  assign ar_err = (s_axi.arsize != 3'b010) || s_axi.arburst[1];
  assign aw_idx = s_axi.awaddr[IDX_W+1:2];
  assign ar_idx = s_axi.araddr[IDX_W+1:2];

  wire unused_addr = ^{s_axi.awaddr[ADDR_W-1:IDX_W+2], s_axi.awaddr[1:0],
                       s_axi.araddr[ADDR_W-1:IDX_W+2], s_axi.araddr[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_fixed_q <= 1'b0;
      w_err_q   <= 1'b0;
      w_over_q  <= 1'b0;
      w_bad_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      bid_q     <= '0;
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_fixed_q <= 1'b0;
      r_err_q   <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rid_q     <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_fixed_q <= w_fixed_d;
      w_err_q   <= w_err_d;
      w_over_q  <= w_over_d;
      w_bad_q   <= w_bad_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      bid_q     <= bid_d;
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_fixed_q <= r_fixed_d;
      r_err_q   <= r_err_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rid_q     <= rid_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_hs) w_state_d = W_DATA;
      W_DATA:  if (w_hs && s_axi.wlast) w_state_d = W_RESP;
      W_RESP:  if (b_hs) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Handshake-ready flags are decoded from the next state so they stay registered.
  always_comb begin
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_fixed_d = w_fixed_q;
    w_err_d   = w_err_q;
    w_over_d  = w_over_q;
    w_bad_d   = w_bad_q;
    bresp_d   = bresp_q;
    bid_d     = bid_q;
    mem_we    = 1'b0;
    w_mis     = 1'b0;
    if (aw_hs) begin
      w_idx_d   = aw_idx;
      w_len_d   = s_axi.awlen;
      w_cnt_d   = '0;
      w_fixed_d = (s_axi.awburst == 2'b00);
      w_err_d   = aw_err;
      w_over_d  = 1'b0;
      w_bad_d   = 1'b0;
      bid_d     = s_axi.awid;
    end else if (w_hs) begin
      // w_over_q marks beats past awlen: accepted, never written.
      mem_we  = !w_err_q && !w_over_q;
      w_idx_d = w_idx_q + IDX_W'(!w_fixed_q);
      w_cnt_d = w_cnt_q + 8'd1;
      if (w_cnt_q == w_len_q) w_over_d = 1'b1;
      if (s_axi.wlast) w_mis = w_over_q || (w_cnt_q != w_len_q);
      else             w_mis = !w_over_q && (w_cnt_q == w_len_q);
      if (w_mis) w_bad_d = 1'b1;
      if (s_axi.wlast)
        bresp_d = (w_err_q || w_bad_q || w_mis) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (s_axi.wstrb[b]) mem[w_idx_q][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_DATA;
      R_DATA:  if (r_hs && rlast_q) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // rdata is loaded one beat ahead so a beat is ready the cycle after AR/R handshakes.
  always_comb begin
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_fixed_d = r_fixed_q;
    r_err_d   = r_err_q;
    rlast_d   = rlast_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rid_d     = rid_q;
    if (ar_hs) begin
      r_err_d   = ar_err;
      r_len_d   = s_axi.arlen;
      r_fixed_d = (s_axi.arburst == 2'b00);
      rid_d     = s_axi.arid;
      rdata_d   = ar_err ? '0 : mem[ar_idx];
      rresp_d   = ar_err ? RESP_SLVERR : RESP_OKAY;
      rlast_d   = (s_axi.arlen == 8'd0);
      r_cnt_d   = '0;
      r_idx_d   = ar_idx + IDX_W'(s_axi.arburst != 2'b00);
    end else if (r_hs) begin
      if (rlast_q) begin
        rlast_d = 1'b0;
      end else begin
        rdata_d = r_err_q ? '0 : mem[r_idx_q];
        r_idx_d = r_idx_q + IDX_W'(!r_fixed_q);
        r_cnt_d = r_cnt_q + 8'd1;
        rlast_d = ((r_cnt_q + 8'd1) == r_len_q);
      end
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.bid     = bid_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rlast   = rlast_q;
  assign s_axi.rid     = rid_q;
endmodule

// File: doc/axi4f_mem_slv.md
# axi4f_mem_slv

AXI4 full-protocol memory slave: the responder end of the AXI4 master agent that drives write and read bursts into the block design. It accepts independent write and read bursts, stores 32-bit words in an internal register array, and returns B and R responses with matching IDs. It sits behind the interconnect at base address 0xC000_0000 and decodes only its own low address bits.

## Interface
- ID_W, 1: width of AWID/BID/ARID/RID.
- ADDR_W, 32: address width. Only bits [log2(DEPTH)+1:2] select a word; upper bits are ignored.
- DEPTH, 16: number of 32-bit words. Must be a power of 2, at least 4.
- clk  in  1  single clock for all channels.
- rst  in  1  asynchronous, active-low reset.
- s_axi_awid/awaddr/awlen/awsize/awburst  in  ID_W/ADDR_W/8/3/2  write address channel.
- s_axi_awvalid in 1, s_axi_awready out 1.
- s_axi_wdata/wstrb/wlast  in  32/4/1; s_axi_wvalid in 1, s_axi_wready out 1.
- s_axi_bid/bresp  out  ID_W/2; s_axi_bvalid out 1, s_axi_bready in 1.
- s_axi_arid/araddr/arlen/arsize/arburst  in  ID_W/ADDR_W/8/3/2; s_axi_arvalid in 1, s_axi_arready out 1.
- s_axi_rid/rdata/rresp/rlast  out  ID_W/32/2/1; s_axi_rvalid out 1, s_axi_rready in 1.

## Operation
- Write FSM has three states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1. On AW handshake, latch id, word index, len, burst and error flag, then go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the beat only if no error and beat count ≤ awlen. Each byte lane is written only where its wstrb bit is 1. The beat counter increments per handshake. On the handshake where wlast=1, go to W_RESP.
  - W_RESP: bvalid=1 and bid = latched id. On B handshake, go to W_IDLE.
- Read FSM has two states: R_IDLE, R_DATA.
  - R_IDLE: arready=1. On AR handshake, latch id, index, len, burst and error flag. Load beat 0 into the rdata register and go to R_DATA.
  - R_DATA: rvalid=1. On each R handshake that is not last, load the next beat. On the handshake with rlast=1, go to R_IDLE.
- Address sequencing:
  - INCR (01): index += 1 per beat, wrapping modulo DEPTH.
  - FIXED (00): index constant.
- Error conditions:
  - AxSIZE != 3'b010, or burst WRAP (10) or reserved (11), sets the error flag.
  - Error writes modify no memory; BRESP = SLVERR (2'b10).
  - Error reads return rdata = 0 and RRESP = SLVERR on every beat, for awlen/arlen+1 beats.
- WLAST mismatch: if wlast arrives before beat awlen, or does not arrive on beat awlen, BRESP = SLVERR.
  - Beats up to and including awlen are still written.
  - Extra beats are accepted and discarded.
  - The FSM waits for wlast regardless.
- Otherwise BRESP/RRESP = OKAY (2'b00). rlast=1 exactly on beat arlen.
- Write and read FSMs run concurrently and independently.
- Same-cycle write and read-load of the same word: the read loads the old data.
- Memory contents are not reset; they are undefined until written.

## Timing
- Reset values: awready=0, wready=0, bvalid=0, arready=0, rvalid=0, rlast=0, bresp=0, rresp=0, bid=0, rid=0, rdata=0.
- Both FSMs reset to their IDLE state. awready and arready rise 1 cycle after rst deasserts.
- Reset asserted mid-burst aborts the burst immediately. Words already written are kept; no response is issued.
- AW handshake at cycle t: wready=1 from t+1. W data is not accepted before the AW handshake.
- Last W handshake at t: bvalid=1 at t+1, held until bready.
- AR handshake at t: rvalid=1 with beat 0 at t+1. With rready held high, one beat per cycle.
- rvalid, rdata, rresp and rlast stay stable while rready=0. bvalid and bresp stay stable while bready=0.
- Single-burst pipeline: awready=0 outside W_IDLE and arready=0 outside R_IDLE. Back-to-back bursts see ≥1 idle cycle.
- All outputs are registered.

## Test plan
- After reset, write INCR len=3 size=4B at 0xC000_0000 with data 0x11111111, 0x22222222, 0x33333333, 0x44444444 → BRESP=OKAY, bid matches awid. Then read INCR len=3 at 0xC000_0000 → same four words, RRESP=OKAY, rlast only on beat 3.
- Write INCR len=1 at word 15 (0xC000_003C), DEPTH=16 → second beat lands in word 0. Reading 1 beat at 0xC000_0000 returns the second beat's data.
- FIXED write len=2 at word 4 with wstrb 4'b0011 on the last beat (data 0xAABBCCDD over prior 0x12345678) → word 4 reads 0x1234CCDD.
- AWSIZE=1 (2B) write, or AWBURST=WRAP → BRESP=SLVERR and memory unchanged. ARBURST=11 with len=2 → 3 beats of rdata=0, RRESP=SLVERR.
- rready toggled randomly and bready held low for 5 cycles → data is stable while stalled, with no lost or duplicated beats. Concurrent write and read bursts to disjoint words both complete correctly.
- rst asserted during beat 2 of a len=7 write → all outputs return to reset values asynchronously. A subsequent full write/read passes.
